calc_display: RTL

- Downstream stage of the calculator core. Consumes the core's result, done, error and op outputs.
- On each new completion it captures the result and converts binary fields to BCD with a sequential double-dabble engine.
- Drives an 8-digit multiplexed, active-low 7-segment display with per-operation digit layouts and an "Err" screen.

---
 rtl/calc_disp_pkg.sv | 53 +++++
 rtl/calc_disp_if.sv | 14 +
 rtl/calc_display_bin2bcd_seq.sv | 61 ++++++
 rtl/calc_display.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_disp_pkg.sv
// Shared types, op/glyph codes, FSM encoding and glyph-to-segment decode for calc_display.
package calc_disp_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned GLYPH_W    = 5;
    localparam int unsigned RES_W      = 16;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_SQRT = 2'b10;
    localparam logic [1:0] OP_BCD  = 2'b11;

    localparam logic [GLYPH_W-1:0] G_BLANK = 5'd10;
    localparam logic [GLYPH_W-1:0] G_DASH  = 5'd11;
    localparam logic [GLYPH_W-1:0] G_E     = 5'd12;
    localparam logic [GLYPH_W-1:0] G_R     = 5'd13;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_CONV    = 2'd2;
    localparam logic [1:0] S_LOAD    = 2'd3;

    typedef logic [GLYPH_W-1:0]                  glyph_t;
    typedef logic [NUM_DIGITS-1:0][GLYPH_W-1:0]  digits_t;
    typedef logic [4:0][3:0]                     bcd5_t;

    typedef struct packed {
        logic             error;
        logic [1:0]       op;
        logic [RES_W-1:0] result;
    } cap_t;

    // Active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] glyph_seg(input glyph_t g);
        case (g)
            5'd0:    glyph_seg = 7'h40;
            5'd1:    glyph_seg = 7'h79;
            5'd2:    glyph_seg = 7'h24;
            5'd3:    glyph_seg = 7'h30;
            5'd4:    glyph_seg = 7'h19;
            5'd5:    glyph_seg = 7'h12;
            5'd6:    glyph_seg = 7'h02;
            5'd7:    glyph_seg = 7'h78;
            5'd8:    glyph_seg = 7'h00;
            5'd9:    glyph_seg = 7'h10;
            G_DASH:  glyph_seg = 7'h3F;
            G_E:     glyph_seg = 7'h06;
            G_R:     glyph_seg = 7'h2F;
            default: glyph_seg = 7'h7F;
        endcase
    endfunction

endpackage

// File: rtl/calc_disp_if.sv
// Core-result inputs and display outputs of calc_display.
interface calc_disp_if;
    logic [1:0]  op;
    logic [15:0] result;
    logic        done;
    logic        error;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;
    logic        busy;

    modport master (output op, result, done, error, input seg, dp, an, busy);
    modport slave  (input op, result, done, error, output seg, dp, an, busy);
endinterface

// File: rtl/calc_display_bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift iteration per cycle, the first one in the start cycle.
module bin2bcd_seq
    import calc_disp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [15:0] value_i,
    input  logic [4:0]  iterations_i,
    output bcd5_t       bcd_o,
    output logic        done_o
);

    bcd5_t       bcd_q, bcd_d, src_bcd, adj;
    logic [15:0] bin_q, bin_d, src_bin;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        step;

    // done_o marks the cycle performing the final iteration
    always_comb begin
        src_bcd = bcd_q;
        src_bin = bin_q;
        cnt_d   = cnt_q;
        step    = 1'b0;
        if (start_i) begin
            src_bcd = '0;
            src_bin = (iterations_i == 5'd8) ? {value_i[7:0], 8'h00} : value_i;
            cnt_d   = iterations_i - 5'd1;
            step    = 1'b1;
        end else if (cnt_q != 5'd0) begin
            cnt_d = cnt_q - 5'd1;
            step  = 1'b1;
        end
        adj = src_bcd;
        for (int k = 0; k < 5; k++) begin
            if (adj[k] >= 4'd5) adj[k] = adj[k] + 4'd3;
        end
        if (step) {bcd_d, bin_d} = {adj, src_bin} << 1;
        else      {bcd_d, bin_d} = {bcd_q, bin_q};
        done_d = (cnt_d == 5'd1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_q  <= '0;
            bin_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            bcd_q  <= bcd_d;
            bin_q  <= bin_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bcd_o  = bcd_q;
    assign done_o = done_q;

endmodule

// File: rtl/calc_display.sv
// Captures calculator results, converts to BCD and scans an 8-digit active-low 7-segment display.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zeros in numeric fields.
module calc_display
    import calc_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    calc_disp_if.slave  core
);

    localparam int unsigned REF_W  = $clog2(REFRESH_DIV);
    localparam int unsigned SCAN_W = $clog2(NUM_DIGITS);

    logic [1:0]       state_q, state_d;
    cap_t             cap_q, cap_d;
    logic             done_in_q, busy_q, busy_d, kick_q, kick_d, phase_q, phase_d;
    logic [2:0][3:0]  qhold_q, qhold_d;
    digits_t          digit_q, digit_d, layout;
    logic [REF_W-1:0] ref_q, ref_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [6:0]       seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic             start_c;
    logic [15:0]      eng_value;
    logic [4:0]       eng_iter;
    bcd5_t            eng_bcd;
    logic             eng_done;
    logic [3:0]       nib;

    assign start_c = core.done & ~done_in_q;

    // Div converts Q first, then R; sqrt only uses the low 10 bits
    always_comb begin
        eng_iter = (cap_q.op == OP_DIV) ? 5'd8 : 5'd16;
        if (cap_q.op == OP_DIV)
            eng_value = phase_q ? {8'h00, cap_q.result[7:0]} : {8'h00, cap_q.result[15:8]};
        else if (cap_q.op == OP_SQRT)
            eng_value = {6'b0, cap_q.result[9:0]};
        else
            eng_value = cap_q.result;
    end

    bin2bcd_seq u_b2b (
        .clk          (clk),
        .reset        (reset),
        .start_i      (kick_q),
        .value_i      (eng_value),
        .iterations_i (eng_iter),
        .bcd_o        (eng_bcd),
        .done_o       (eng_done)
    );

`ifdef LEADING_ZERO_BLANK_EN
    function automatic digits_t blank_lead(input digits_t d, input int msb, input int lsb);
        logic lead;
        blank_lead = d;
        lead       = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
            if (i <= msb && i > lsb) begin
                if (lead && d[i] == 5'd0) blank_lead[i] = G_BLANK;
                else                      lead = 1'b0;
            end
        end
    endfunction
`endif

    // Digit layout written in LOAD
    always_comb begin
        layout = {NUM_DIGITS{G_BLANK}};
        nib    = 4'd0;
        if (cap_q.error) begin
            layout[2] = G_E;
            layout[1] = G_R;
            layout[0] = G_R;
        end else begin
            case (cap_q.op)
                OP_MULT: for (int k = 0; k < 5; k++) layout[k] = {1'b0, eng_bcd[k]};
                OP_SQRT: for (int k = 0; k < 4; k++) layout[k] = {1'b0, eng_bcd[k]};
                OP_DIV: begin
                    for (int k = 0; k < 3; k++) begin
                        layout[k + 4] = {1'b0, qhold_q[k]};
                        layout[k]     = {1'b0, eng_bcd[k]};
                    end
                    layout[3] = G_DASH;
                end
                default: begin
                    for (int k = 0; k < 3; k++) begin
                        nib       = cap_q.result[k*4 +: 4];
                        layout[k] = (nib > 4'd9) ? G_DASH : {1'b0, nib};
                    end
                end
            endcase
`ifdef LEADING_ZERO_BLANK_EN
            case (cap_q.op)
                OP_MULT: layout = blank_lead(layout, 4, 0);
                OP_SQRT: layout = blank_lead(layout, 3, 0);
                OP_DIV:  layout = blank_lead(blank_lead(layout, 6, 4), 2, 0);
                default: ;
            endcase
`endif
        end
    end

    // Control FSM; a done edge is only accepted in IDLE
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        busy_d  = busy_q;
        kick_d  = 1'b0;
        phase_d = phase_q;
        qhold_d = qhold_q;
        digit_d = digit_q;
        if (kick_q && phase_q) qhold_d = eng_bcd[2:0];
        case (state_q)
            S_IDLE: begin
                if (start_c) begin
                    cap_d.error  = core.error;
                    cap_d.op     = core.op;
                    cap_d.result = core.result;
                    busy_d       = 1'b1;
                    state_d      = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                phase_d = 1'b0;
                if (cap_q.error || cap_q.op == OP_BCD) begin
                    state_d = S_LOAD;
                end else begin
                    kick_d  = 1'b1;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                if (eng_done) begin
                    if (cap_q.op == OP_DIV && !phase_q) begin
                        phase_d = 1'b1;
                        kick_d  = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                digit_d = layout;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Free-running digit scan
    always_comb begin
        ref_d  = ref_q + REF_W'(1);
        scan_d = scan_q;
        if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
            ref_d  = '0;
            scan_d = scan_q + SCAN_W'(1);
        end
        seg_d = glyph_seg(digit_q[scan_q]);
        an_d  = ~(NUM_DIGITS'(1) << scan_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cap_q     <= '0;
            done_in_q <= 1'b0;
            busy_q    <= 1'b0;
            kick_q    <= 1'b0;
            phase_q   <= 1'b0;
            qhold_q   <= '0;
            digit_q   <= {NUM_DIGITS{G_BLANK}};
            ref_q     <= '0;
            scan_q    <= '0;
            seg_q     <= 7'h7F;
            an_q      <= '1;
        end else begin
            state_q   <= state_d;
            cap_q     <= cap_d;
            done_in_q <= core.done;
            busy_q    <= busy_d;
            kick_q    <= kick_d;
            phase_q   <= phase_d;
            qhold_q   <= qhold_d;
            digit_q   <= digit_d;
            ref_q     <= ref_d;
            scan_q    <= scan_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign core.seg  = seg_q;
    assign core.an   = an_q;
    assign core.dp   = 1'b1;
    assign core.busy = busy_q;

endmodule
